// File: rtl/laser_enable_sequencer.sv
// Purpose : sequences laser turn-on (DAC limit load, settle, enable) and latches over-current/config faults.
// Latency : every output is registered; outputs reflect the next-state decision one clk after inputs are sampled.
// Backpr.  : none; cfg_done/fault_clear are single-cycle strobes, ignored when they arrive in the wrong state.
//
// Ports:
//   clk, rstn       - 10 MHz system clock, synchronous active-low reset
//   enable_req      - host laser-on request (level)
//   over_current    - ADC over-current flag (level, clk-synchronous)
//   fault_clear     - host fault-clear strobe
//   cfg_done        - DAC limit-load complete strobe
//   cfg_start       - DAC limit-load request strobe (first CONFIG cycle)
//   laser_en        - laser drive permitted (ACTIVE only)
//   shutdown_n      - low while a fault is latched
//   state           - current state encoding
//   fault_cause     - 01 over-current, 10 config timeout, 00 none
//   fault_count     - saturating count of FAULT entries
module laser_enable_sequencer #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int CFG_TIMEOUT   = 4095,
    parameter int OC_FILTER     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable_req,
    input  logic       over_current,
    input  logic       fault_clear,
    input  logic       cfg_done,
    output logic       cfg_start,
    output logic       laser_en,
    output logic       shutdown_n,
    output logic [2:0] state,
    output logic [1:0] fault_cause,
    output logic [7:0] fault_count
);

    localparam int TMO_NEED = $clog2(CFG_TIMEOUT + 1);
    localparam int SET_NEED = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W    = (TMO_NEED > 12) ? TMO_NEED : 12;
    localparam int SET_W    = (SET_NEED > 16) ? SET_NEED : 16;

    // Counters start at 0 on the first cycle of a state, so the last
    // permitted cycle is at count N-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CFG_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       OC_MAX   = 8'(OC_FILTER);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       cause_d;
    logic [7:0]       oc_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SET_W-1:0] set_cnt;
    logic             oc_qual;
    logic             fault_entry;

    assign state       = state_q;
    assign oc_qual     = (oc_cnt == OC_MAX);
    assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

    always_comb begin
        state_d = state_q;
        cause_d = fault_cause;
        // A qualified over-current overrides every other transition.
        if (oc_qual && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
            cause_d = 2'b01;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_req) state_d = ST_CONFIG;
                end
                ST_CONFIG: begin
                    if (!enable_req) begin
                        state_d = ST_IDLE;
                    end else if (cfg_done) begin
                        state_d = ST_SETTLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_d = ST_FAULT;
                        cause_d = 2'b10;
                    end
                end
                ST_SETTLE: begin
                    if (!enable_req) begin
                        state_d = ST_IDLE;
                    end else if (set_cnt == SET_LAST) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable_req) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    // Clear only once the host has dropped the request and
                    // the over-current condition is gone.
                    if (fault_clear && !enable_req && !over_current) begin
                        state_d = ST_IDLE;
                        cause_d = 2'b00;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cause_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            oc_cnt      <= 8'd0;
            tmo_cnt     <= '0;
            set_cnt     <= '0;
            cfg_start   <= 1'b0;
            laser_en    <= 1'b0;
            shutdown_n  <= 1'b1;
            fault_cause <= 2'b00;
            fault_count <= 8'd0;
        end else begin
            state_q <= state_d;

            if (!over_current) begin
                oc_cnt <= 8'd0;
            end else if (!oc_qual) begin
                oc_cnt <= oc_cnt + 8'd1;
            end

            // Counters restart on any state change, so each entry begins at 0.
            tmo_cnt <= ((state_d == ST_CONFIG) && (state_q == ST_CONFIG)) ?
                       tmo_cnt + TMO_W'(1) : '0;
            set_cnt <= ((state_d == ST_SETTLE) && (state_q == ST_SETTLE)) ?
                       set_cnt + SET_W'(1) : '0;

            // Outputs decoded from the next state so they line up with state.
            cfg_start   <= (state_d == ST_CONFIG) && (state_q != ST_CONFIG);
            laser_en    <= (state_d == ST_ACTIVE);
            shutdown_n  <= (state_d != ST_FAULT);
            fault_cause <= cause_d;

            if (fault_entry && (fault_count != 8'hFF)) begin
                fault_count <= fault_count + 8'd1;
            end
        end
    end

endmodule
